mem_lsu_ctrl: RTL
=================

Name: mem_lsu_ctrl

Overview:
- Parametrised load/store controller for the memory stage; successor to the fixed 32-bit, single-cycle data-memory access.
- Accepts one load/store from the MEM pipeline register over a valid/ready handshake.
- Drives a word-aligned data-memory bus with byte enables and its own request/response handshake, then returns sign/zero-extended load data plus rd to writeback.
- Optionally splits accesses that cross a word boundary into two bus beats.

Parameters:
XLEN, 32, data width in bits; 32 or 64.
ADDR_W, 32, byte-address width.
RD_W, 5, destination register index width.

Ports:
clk  in  1  clock
arst_n  in  1  asynchronous active-low reset
req_valid  in  1  MEM-stage request valid
req_ready  out  1  controller can accept a request
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 dword (XLEN=64 only)
req_unsigned  in  1  zero-extend load result
req_addr  in  ADDR_W  byte address
req_wdata  in  XLEN  store data, LSB-justified
req_rd  in  RD_W  load destination register
dm_req_valid  out  1  bus request valid
dm_req_ready  in  1  bus accepts request
dm_req_we  out  1  bus write
dm_req_addr  out  ADDR_W  word-aligned address (low log2(XLEN/8) bits zero)
dm_req_wdata  out  XLEN  lane-shifted write data
dm_req_be  out  XLEN/8  byte enables
dm_rsp_valid  in  1  bus response valid (one per accepted request)
dm_rsp_rdata  in  XLEN  bus read data
resp_valid  out  1  one-cycle pulse: access complete
resp_rdata  out  XLEN  extended load data; 0 for stores
resp_rd  out  RD_W  echoed req_rd; 0 for stores
resp_err  out  1  misaligned fault (only when split disabled or size illegal)

Behaviour:
- Reset values: all outputs 0; FSM in IDLE. req_ready is combinational (IDLE & arst_n), so it is also 0 while reset is asserted.
- States: IDLE, BEAT1, WAIT1, BEAT2, WAIT2, DONE.
- IDLE: req_ready=1. On req_valid:
  - Capture the request.
  - Compute off = addr mod (XLEN/8) and nbytes = 1<<size.
  - Go to BEAT1, or to DONE with err if the access is illegal.
- BEAT1:
  - dm_req_valid=1, dm_req_addr = addr with low bits cleared.
  - be = ((1<<nbytes)-1) << off, truncated to XLEN/8 bits.
  - wdata = req_wdata << (8*off).
  - Hold all bus outputs stable until dm_req_ready; then go to WAIT1.
- WAIT1: on dm_rsp_valid, latch the lower part of the data. Go to BEAT2 if crossing (off+nbytes > XLEN/8), else DONE.
- BEAT2:
  - Address = aligned address + XLEN/8, wrapping modulo 2^ADDR_W.
  - be = remaining low lanes.
  - wdata = req_wdata >> (8*(XLEN/8-off)).
  - Same hold rule as BEAT1; then go to WAIT2.
- WAIT2: on dm_rsp_valid, merge the upper bytes; go to DONE.
- DONE:
  - resp_valid=1 for exactly one cycle with registered resp_rdata/resp_rd/resp_err; return to IDLE.
  - The next request can be accepted no earlier than the following cycle.
- Load data: extract nbytes starting at byte off (across both beats when split). Sign-extend from the top bit unless req_unsigned; then zero-extend.
- Aligned access latency: request accepted at cycle 0, dm_req_valid at cycle 1. resp_valid follows the cycle after dm_rsp_valid.
- Illegal size (11 with XLEN=32): no bus traffic; DONE with resp_err=1.
- A dm_rsp_valid outside WAIT1/WAIT2 is ignored.
- arst_n asserted mid-transaction aborts immediately: no resp_valid, and dm_req_valid drops asynchronously.
- No backpressure on resp; the writeback stage always accepts.

Optional Feature:
- Macro: MEM_LSU_MISALIGNED_SPLIT_EN.
- Defined: word-crossing accesses are split into two beats as above.
- Undefined:
  - Any access with off mod nbytes != 0 goes directly IDLE→DONE with resp_err=1, resp_rdata=0, and no bus request.
  - BEAT2/WAIT2 logic is omitted.
- Naturally aligned accesses behave identically in both builds.

Test Plan:
- XLEN=32, load word at 0x100. Bus returns 0x8000_00F0 with 0 wait cycles → dm_req_be=1111, addr 0x100; resp_rdata=0x8000_00F0, resp_rd=req_rd, resp_valid at cycle 3 after acceptance.
- Load byte, signed, at 0x103 with bus data 0x8A00_0000 → be=1000, resp_rdata=0xFFFF_FF8A. Same access with req_unsigned=1 → 0x0000_008A.
- Store half 0xBEEF to 0x202 with dm_req_ready held low for 3 cycles → dm_req_wdata=0xBEEF_0000 and be=1100 held stable throughout; exactly one dm_req handshake; resp_valid with resp_rdata=0.
- Split enabled, load word at 0x0FE:
  - beat1: addr 0x0FC, be 1100, data 0x3344_xxxx.
  - beat2: addr 0x100, be 0011, data 0xxxxx_1122.
  - resp_rdata=0x1122_3344.
- Split disabled, same access → no dm_req_valid; resp_err=1 one cycle after acceptance.
- arst_n pulsed low while in WAIT1 → all outputs 0, no resp_valid, req_ready=1 after release; a following aligned load completes normally.

Source files
------------

// File: rtl/mem_lsu_ctrl.sv
// mem_lsu_ctrl: load/store controller for the memory stage.
//
// This block takes one load or store from the MEM pipeline register over a
// valid/ready handshake. It issues the access on a word-aligned data-memory
// bus with byte enables. It then returns the extended load data and rd to
// writeback as a one-cycle pulse.
//
// Parameters:
//   XLEN   data width (32 or 64)
//   ADDR_W byte-address width
//   RD_W   destination register index width
//
// Ports:
//   clk, arst_n              clock, asynchronous active-low reset
//   req_valid/req_ready      MEM-stage request handshake (req_ready = IDLE & arst_n)
//   req_we, req_size,        store flag, size (00 B, 01 H, 10 W, 11 D),
//   req_unsigned, req_addr,  zero-extend flag, byte address,
//   req_wdata, req_rd        LSB-justified store data, load destination
//   dm_req_*                 bus request: valid/ready, we, aligned addr,
//                            lane-shifted wdata, byte enables
//   dm_rsp_valid/rdata       bus response (one per accepted request)
//   resp_valid               one-cycle completion pulse
//   resp_rdata, resp_rd      extended load data / rd (0 for stores)
//   resp_err                 misaligned or illegal-size fault
//
// Build option:
//   MEM_LSU_MISALIGNED_SPLIT_EN  when defined, word-crossing accesses are
//   split into two bus beats. When undefined, any access that is not
//   naturally aligned faults without bus traffic.

module mem_lsu_ctrl #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int RD_W   = 5
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  input  logic [RD_W-1:0]     req_rd,
  output logic                dm_req_valid,
  input  logic                dm_req_ready,
  output logic                dm_req_we,
  output logic [ADDR_W-1:0]   dm_req_addr,
  output logic [XLEN-1:0]     dm_req_wdata,
  output logic [XLEN/8-1:0]   dm_req_be,
  input  logic                dm_rsp_valid,
  input  logic [XLEN-1:0]     dm_rsp_rdata,
  output logic                resp_valid,
  output logic [XLEN-1:0]     resp_rdata,
  output logic [RD_W-1:0]     resp_rd,
  output logic                resp_err
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BEAT1 = 3'd1,
    WAIT1 = 3'd2,
    BEAT2 = 3'd3,
    WAIT2 = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t              state;

  // Captured request
  logic                we_q;
  logic [1:0]          size_q;
  logic                uns_q;
  logic [ADDR_W-1:0]   addr_q;    // word-aligned
  logic [OFF_W-1:0]    off_q;
  logic [XLEN-1:0]     wdata_q;
  logic [RD_W-1:0]     rd_q;

  // Registered response
  logic [XLEN-1:0]     resp_rdata_q;
  logic [RD_W-1:0]     resp_rd_q;
  logic                resp_err_q;

  // Request-side decode
  logic [OFF_W-1:0]    in_off;
  logic                in_illegal;

  // Captured-request decode
  int unsigned         nbytes_q;
  logic [NB-1:0]       mask_n;
  logic [XLEN-1:0]     raw;
  logic [XLEN-1:0]     load_result;

`ifdef MEM_LSU_MISALIGNED_SPLIT_EN
  logic [XLEN-1:0]     lo_q;      // lower-beat data for a split load
  logic                crossing;
  logic [2*NB-1:0]     be_wide;
  logic [2*XLEN-1:0]   wdata_wide;
`endif

  // Sign- or zero-extend the low 2^size bytes of raw to XLEN bits.
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] r,
                                             input logic [1:0]      size,
                                             input logic            uns);
    int          nb;
    int          sb;
    logic [XLEN-1:0] m;
    logic        sgn;
    nb = 1 << size;
    sb = 8 * nb - 1;
    if (sb > XLEN - 1) sb = XLEN - 1;
    // A full-width access shifts the 1 out, so the mask becomes all ones.
    m   = (XLEN'(1) << (8 * nb)) - XLEN'(1);
    sgn = 1'(r >> sb);
    extend = r & m;
    if (!uns && sgn) extend = extend | ~m;
  endfunction

  always_comb begin
    in_off     = req_addr[OFF_W-1:0];
    in_illegal = (XLEN == 32) && (req_size == 2'b11);
`ifndef MEM_LSU_MISALIGNED_SPLIT_EN
    if ((in_off & OFF_W'((1 << req_size) - 1)) != '0) in_illegal = 1'b1;
`endif
  end

  always_comb begin
    nbytes_q = 1 << size_q;
    mask_n   = NB'((1 << nbytes_q) - 1);
`ifdef MEM_LSU_MISALIGNED_SPLIT_EN
    crossing   = (int'(off_q) + int'(nbytes_q)) > NB;
    be_wide    = {{NB{1'b0}}, mask_n} << off_q;
    wdata_wide = {{XLEN{1'b0}}, wdata_q} << (8 * off_q);
    if (state == WAIT2) raw = XLEN'({dm_rsp_rdata, lo_q} >> (8 * off_q));
    else                raw = dm_rsp_rdata >> (8 * off_q);
`else
    raw = dm_rsp_rdata >> (8 * off_q);
`endif
    load_result = extend(raw, size_q, uns_q);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state        <= IDLE;
      we_q         <= 1'b0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      off_q        <= '0;
      wdata_q      <= '0;
      rd_q         <= '0;
      resp_rdata_q <= '0;
      resp_rd_q    <= '0;
      resp_err_q   <= 1'b0;
`ifdef MEM_LSU_MISALIGNED_SPLIT_EN
      lo_q         <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            off_q   <= in_off;
            wdata_q <= req_wdata;
            rd_q    <= req_rd;
            if (in_illegal) begin
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
              resp_rd_q    <= '0;
              state        <= DONE;
            end else begin
              resp_err_q <= 1'b0;
              state      <= BEAT1;
            end
          end
        end
        BEAT1: begin
          if (dm_req_ready) state <= WAIT1;
        end
        WAIT1: begin
          if (dm_rsp_valid) begin
`ifdef MEM_LSU_MISALIGNED_SPLIT_EN
            if (crossing) begin
              lo_q  <= dm_rsp_rdata;
              state <= BEAT2;
            end else begin
`else
            begin
`endif
              resp_rdata_q <= we_q ? '0 : load_result;
              resp_rd_q    <= we_q ? '0 : rd_q;
              state        <= DONE;
            end
          end
        end
`ifdef MEM_LSU_MISALIGNED_SPLIT_EN
        BEAT2: begin
          if (dm_req_ready) state <= WAIT2;
        end
        WAIT2: begin
          if (dm_rsp_valid) begin
            resp_rdata_q <= we_q ? '0 : load_result;
            resp_rd_q    <= we_q ? '0 : rd_q;
            state        <= DONE;
          end
        end
`endif
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Bus and response outputs decode from state alone, so the asynchronous
  // reset of state drops dm_req_valid immediately.
  always_comb begin
    dm_req_valid = 1'b0;
    dm_req_we    = 1'b0;
    dm_req_addr  = '0;
    dm_req_wdata = '0;
    dm_req_be    = '0;
    case (state)
      BEAT1: begin
        dm_req_valid = 1'b1;
        dm_req_we    = we_q;
        dm_req_addr  = addr_q;
`ifdef MEM_LSU_MISALIGNED_SPLIT_EN
        dm_req_be    = be_wide[NB-1:0];
        dm_req_wdata = wdata_wide[XLEN-1:0];
`else
        dm_req_be    = mask_n << off_q;
        dm_req_wdata = wdata_q << (8 * off_q);
`endif
      end
`ifdef MEM_LSU_MISALIGNED_SPLIT_EN
      BEAT2: begin
        dm_req_valid = 1'b1;
        dm_req_we    = we_q;
        dm_req_addr  = addr_q + ADDR_W'(NB);
        dm_req_be    = be_wide[2*NB-1:NB];
        dm_req_wdata = wdata_wide[2*XLEN-1:XLEN];
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE) && arst_n;
    resp_valid = (state == DONE);
    resp_rdata = (state == DONE) ? resp_rdata_q : '0;
    resp_rd    = (state == DONE) ? resp_rd_q    : '0;
    resp_err   = (state == DONE) ? resp_err_q   : 1'b0;
  end

endmodule
